// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock over a
// combinational inverse-round datapath, with round keys read from an external store.

package aes_inv_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

endpackage

module inv_shift_rows (
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end
endmodule

module inv_sub_bytes
  import aes_inv_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_out[127-8*i -: 8] = inv_sbox(state_in[127-8*i -: 8]);
  end
endmodule

module inv_mix_columns
  import aes_inv_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    assign a0 = state_in[127-32*c -: 8];
    assign a1 = state_in[119-32*c -: 8];
    assign a2 = state_in[111-32*c -: 8];
    assign a3 = state_in[103-32*c -: 8];
    assign state_out[127-32*c -: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
    assign state_out[119-32*c -: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
    assign state_out[111-32*c -: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
    assign state_out[103-32*c -: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
  end
endmodule

module aes_inv_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] plaintext_q, plaintext_d;
  logic         done_q, done_d;

  logic [127:0] isr_s;
  logic [127:0] isb_s;
  logic [127:0] ark_s;
  logic [127:0] imc_s;

  inv_shift_rows  u_isr (.state_in(st_q),  .state_out(isr_s));
  inv_sub_bytes   u_isb (.state_in(isr_s), .state_out(isb_s));
  assign ark_s = isb_s ^ round_key;
  inv_mix_columns u_imc (.state_in(ark_s), .state_out(imc_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      st_q        <= 128'h0;
      rnd_q       <= 4'd0;
      plaintext_q <= 128'h0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      rnd_q       <= rnd_d;
      plaintext_q <= plaintext_d;
      done_q      <= done_d;
    end
  end

  // The ROUND key index is clamped so a corrupted counter can never address past key 10.
  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    plaintext_d = plaintext_q;
    done_d      = 1'b0;
    rk_idx      = 4'd10;
    case (fsm_q)
      IDLE: begin
        rk_idx = 4'd10;
        if (start) begin
          st_d  = ciphertext ^ round_key;
          rnd_d = 4'd9;
          fsm_d = ROUND;
        end else begin
          fsm_d = IDLE;
        end
      end
      ROUND: begin
        rk_idx = (rnd_q > 4'd10) ? 4'd10 : rnd_q;
        st_d   = imc_s;
        if (rnd_q == 4'd1) begin
          fsm_d = FINAL;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      FINAL: begin
        rk_idx      = 4'd0;
        plaintext_d = ark_s;
        done_d      = 1'b1;
        fsm_d       = IDLE;
      end
      default: begin
        rk_idx = 4'd10;
        fsm_d  = IDLE;
      end
    endcase
  end

  assign busy      = (fsm_q != IDLE);
  assign plaintext = plaintext_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench for aes_inv_round_ctrl: expectations come from FIPS-197 vectors
// and from a forward AES-128 encryptor (random plaintext in, ciphertext to the DUT).

module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = 128'h0;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  logic [127:0] rk_mem [11];
  logic [7:0]   sbox [256];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;
  exp_t exp_q[$];
  logic [127:0] last_pt = 128'h0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  aes_inv_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .round_key  (round_key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store: asynchronous read by index.
  assign round_key = (int'(rk_idx) <= 10) ? rk_mem[int'(rk_idx)] : 128'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Forward S-box from its definition: brute-force inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward AES-128 cipher using the schedule currently in rk_mem.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] blk;
    blk = pt ^ rk_mem[0];
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul(8'h02, a1) ^ mul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul(8'h02, a2) ^ mul(8'h03, a3);
          s[4*c+3] = mul(8'h03, a0) ^ a1 ^ a2 ^ mul(8'h02, a3);
        end
      end
      blk = rk_mem[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ blk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
    return blk;
  endfunction

  // Monitor: expected busy/rk_idx/done/plaintext follow from the pending block's due cycle.
  always @(negedge clk) begin : monitor
    logic       busy_e;
    logic [3:0] rk_e;
    if (!rst) begin
      busy_e = 1'b0;
      rk_e   = 4'd10;
      if (exp_q.size() > 0 && cyc < exp_q[0].due) begin
        busy_e = 1'b1;
        rk_e   = 4'(exp_q[0].due - cyc - 1);
      end
      check("busy", {127'h0, busy}, {127'h0, busy_e});
      check("rk_idx", {124'h0, rk_idx}, {124'h0, rk_e});
      if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
        check("done_pulse", {127'h0, done}, 128'h1);
        check("plaintext", plaintext, exp_q[0].pt);
        last_pt = exp_q[0].pt;
        void'(exp_q.pop_front());
      end else begin
        check("done_idle", {127'h0, done}, 128'h0);
        check("plaintext_hold", plaintext, last_pt);
      end
    end
  end

  // Issue one block; abort_at>0 pulses rst before edge abort_at of the block.
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input bit hold, input int abort_at);
    load_key(key);
    ciphertext = ct;
    start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{pt: pt, due: cyc + 10});
    ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 1; k <= 10; k++) begin
      if (!hold) start = 1'($urandom_range(0, 1));
      if (k == abort_at) begin
        #1;
        rst = 1'b1;
        start = 1'b0;
        exp_q.delete();
        last_pt = 128'h0;
        #1;
        check("abort_busy", {127'h0, busy}, 128'h0);
        check("abort_done", {127'h0, done}, 128'h0);
        check("abort_plaintext", plaintext, 128'h0);
        check("abort_rk_idx", {124'h0, rk_idx}, 128'd10);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    logic [127:0] key;
    logic [127:0] pt;
    int           gap;
    build_sbox();
    for (int r = 0; r < 11; r++) rk_mem[r] = 128'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {127'h0, busy}, 128'h0);
    check("reset_done", {127'h0, done}, 128'h0);
    check("reset_plaintext", plaintext, 128'h0);
    check("reset_rk_idx", {124'h0, rk_idx}, 128'd10);
    rst = 1'b0;

    // Idle window: the monitor checks every cycle.
    repeat (20) @(posedge clk);
    #1;

    load_key(KEY_C);
    check("key_c1_rk10", rk_mem[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    run_block(KEY_B, CT_B, PT_B, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    run_block(KEY_C, CT_C, PT_C, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;

    // start held high across consecutive blocks
    run_block(KEY_B, CT_B, PT_B, 1'b1, 0);
    run_block(KEY_C, CT_C, PT_C, 1'b1, 0);
    run_block(KEY_B, CT_B, PT_B, 1'b1, 0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mid-block reset, then a clean run
    run_block(KEY_B, CT_B, PT_B, 1'b0, 5);
    repeat (15) @(posedge clk);
    #1;
    run_block(KEY_C, CT_C, PT_C, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      gap = $urandom_range(0, 3);
      load_key(key);
      run_block(key, encrypt(pt), pt, (gap == 0), 0);
      if (gap > 0) begin
        start = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("all_blocks_completed", 128'(exp_q.size()), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
